// File: rtl/cp0_cause_if.sv
// Pipeline/CP0 side bus of the Cause register and interrupt controller.
interface cp0_cause_if;
    logic        mtc0_we;
    logic [31:0] mtc0_wdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [1:0]  exc_ce;
    logic [7:0]  status_im;
    logic        int_en;
    logic        rd_en;
    logic        int_ack;
    logic        int_req;
    logic [2:0]  int_line;
    logic [31:0] read_data;

    // Pipeline control / CP0 glue side
    modport master (
        output mtc0_we, mtc0_wdata, exc_valid, exc_code, exc_bd, exc_ce,
               status_im, int_en, rd_en, int_ack,
        input  int_req, int_line, read_data
    );

    // Cause controller side
    modport slave (
        input  mtc0_we, mtc0_wdata, exc_valid, exc_code, exc_bd, exc_ce,
               status_im, int_en, rd_en, int_ack,
        output int_req, int_line, read_data
    );
endinterface

// File: rtl/cp0_cause_ctrl.sv
// CP0 Cause register with hardware interrupt synchronisers and a
// request/acknowledge interrupt controller towards the pipeline.
module cp0_cause_ctrl #(
    parameter int unsigned NUM_HW_IRQ  = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMER_LINE  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_HW_IRQ-1:0] i_hw_irq,
    input  logic                  i_timer_irq,
    cp0_cause_if.slave            bus
);

    localparam int unsigned IP_HW_W = 6;
    localparam int unsigned EXC_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BLOCK = 2'd2
    } state_t;

    logic [NUM_HW_IRQ-1:0] r_sync [SYNC_STAGES];
    logic                  r_ti;
    logic [1:0]            r_ip_sw;
    logic                  r_iv;
    logic                  r_bd;
    logic [1:0]            r_ce;
    logic [EXC_W-1:0]      r_exc_code;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_int_req;
    logic [2:0]            r_int_line;
    logic [2:0]            w_line_nxt;

    logic [IP_HW_W-1:0]    w_ip_hw;
    logic [7:0]            w_ip;
    logic [7:0]            w_pending;
    logic [2:0]            w_hi_idx;
    logic                  w_take_int;
    logic [31:0]           w_cause;
    logic                  w_unused;

    // Highest set bit index of an 8-bit vector (bit 7 wins)
    function automatic logic [2:0] f_hi_idx(input logic [7:0] v);
        f_hi_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) f_hi_idx = 3'(i);
        end
    endfunction

    // Synchronise hw_irq lines and register the timer interrupt
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                r_sync[s] <= '0;
            end
            r_ti <= 1'b0;
        end else begin
            r_sync[0] <= i_hw_irq;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_ti <= i_timer_irq;
        end
    end

    // Map synchronised lines onto IP[7:2]; unimplemented lines read 0
    for (genvar g = 0; g < int'(IP_HW_W); g++) begin : g_ip
        if (g < int'(NUM_HW_IRQ)) begin : g_used
            if (g == int'(TIMER_LINE)) begin : g_timer
                assign w_ip_hw[g] = r_sync[SYNC_STAGES-1][g] | r_ti;
            end else begin : g_plain
                assign w_ip_hw[g] = r_sync[SYNC_STAGES-1][g];
            end
        end else begin : g_tied
            assign w_ip_hw[g] = 1'b0;
        end
    end

    assign w_ip       = {w_ip_hw, r_ip_sw};
    assign w_pending  = w_ip & bus.status_im;
    assign w_hi_idx   = f_hi_idx(w_pending);
    assign w_take_int = (r_state == ST_REQ) & bus.int_ack & ~bus.exc_valid;

    // Writable Cause fields: software IP/IV from MTC0, BD/CE/ExcCode from commits
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ip_sw    <= 2'b00;
            r_iv       <= 1'b0;
            r_bd       <= 1'b0;
            r_ce       <= 2'b00;
            r_exc_code <= '0;
        end else begin
            if (bus.mtc0_we) begin
                r_ip_sw <= bus.mtc0_wdata[9:8];
                r_iv    <= bus.mtc0_wdata[23];
            end
            if (bus.exc_valid) begin
                r_bd       <= bus.exc_bd;
                r_ce       <= bus.exc_ce;
                r_exc_code <= bus.exc_code;
            end else if (w_take_int) begin
                r_bd       <= bus.exc_bd;
                r_exc_code <= '0;
            end
        end
    end

    // Interrupt FSM state and registered request outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_int_req  <= 1'b0;
            r_int_line <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_int_req  <= (w_state_nxt == ST_REQ);
            r_int_line <= w_line_nxt;
        end
    end

    // Interrupt FSM next state; int_line tracks the top pending line while requesting
    always_comb begin
        w_state_nxt = r_state;
        w_line_nxt  = r_int_line;
        case (r_state)
            ST_IDLE: begin
                if (bus.int_en && (w_pending != 8'h00)) begin
                    w_state_nxt = ST_REQ;
                    w_line_nxt  = w_hi_idx;
                end
            end
            ST_REQ: begin
                if (bus.exc_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.int_ack) begin
                    w_state_nxt = ST_BLOCK;
                end else if ((w_pending == 8'h00) || !bus.int_en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_line_nxt  = w_hi_idx;
                end
            end
            ST_BLOCK: begin
                if (!bus.int_en) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_cause = {r_bd, r_ti, r_ce, 4'b0000, r_iv, 7'b0000000,
                      w_ip, 1'b0, r_exc_code, 2'b00};

    assign bus.read_data = bus.rd_en ? w_cause : 32'h0;
    assign bus.int_req   = r_int_req;
    assign bus.int_line  = r_int_line;

    // Write-data bits with no backing Cause field
    assign w_unused = ^{bus.mtc0_wdata[31:24], bus.mtc0_wdata[22:10],
                        bus.mtc0_wdata[7:0]};

endmodule

// File: tb/tb_cp0_cause_ctrl.sv
// Self-checking bench for cp0_cause_ctrl: directed table, hand sequences,
// randomized traffic against a behavioural model, and a reduced configuration.
module tb_cp0_cause_ctrl;

    localparam int NHW = 6;
    localparam int SS  = 2;
    localparam int TL  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] hw;
    logic       timer;
    logic       rst2;
    logic [1:0] hw2;
    logic       timer2;

    int n_chk  = 0;
    int n_fail = 0;

    cp0_cause_if bus ();
    cp0_cause_if bus2 ();

    cp0_cause_ctrl #(.NUM_HW_IRQ(NHW), .SYNC_STAGES(SS), .TIMER_LINE(TL)) dut (
        .i_clk(clk), .i_rst(rst), .i_hw_irq(hw), .i_timer_irq(timer), .bus(bus)
    );

    cp0_cause_ctrl #(.NUM_HW_IRQ(2), .SYNC_STAGES(2), .TIMER_LINE(1)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_hw_irq(hw2), .i_timer_irq(timer2), .bus(bus2)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit [5:0] m_q[$];
    bit       m_ti;
    bit [1:0] m_sw;
    bit       m_iv, m_bd;
    bit [1:0] m_ce;
    bit [4:0] m_exc;
    bit       m_req, m_blk;
    int       m_line;

    function automatic int m_ip();
        int ip;
        ip = int'(m_sw);
        for (int i = 0; i < NHW; i++) if (m_q[0][i]) ip = ip | (1 << (i + 2));
        if (m_ti) ip = ip | (1 << (TL + 2));
        return ip;
    endfunction

    function automatic bit [31:0] m_cause();
        bit [31:0] c;
        c = (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ce) << 28) |
            (32'(m_iv) << 23) | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
        return c;
    endfunction

    function automatic void model_reset();
        m_q = {};
        for (int i = 0; i < SS; i++) m_q.push_back(6'h00);
        m_ti = 0; m_sw = 0; m_iv = 0; m_bd = 0; m_ce = 0; m_exc = 0;
        m_req = 0; m_blk = 0; m_line = 0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    function automatic void model_step();
        int pend, hi;
        bit take;
        if (rst) begin
            model_reset();
            return;
        end
        pend = m_ip() & int'(bus.status_im);
        hi = 0;
        for (int i = 7; i >= 0; i--) if (pend[i]) begin hi = i; break; end
        take = m_req && bus.int_ack && !bus.exc_valid;
        if (m_req) begin
            if (bus.exc_valid) m_req = 0;
            else if (bus.int_ack) begin m_req = 0; m_blk = 1; end
            else if (pend == 0 || !bus.int_en) m_req = 0;
            else m_line = hi;
        end else if (m_blk) begin
            if (!bus.int_en) m_blk = 0;
        end else if (bus.int_en && pend != 0) begin
            m_req = 1; m_line = hi;
        end
        if (bus.mtc0_we) begin
            m_sw = bus.mtc0_wdata[9:8];
            m_iv = bus.mtc0_wdata[23];
        end
        if (bus.exc_valid) begin
            m_bd = bus.exc_bd; m_ce = bus.exc_ce; m_exc = bus.exc_code;
        end else if (take) begin
            m_bd = bus.exc_bd; m_exc = 5'd0;
        end
        m_q.push_back(hw);
        void'(m_q.pop_front());
        m_ti = timer;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_rd", bus.read_data, bus.rd_en ? m_cause() : 32'h0);
        chk("model_req", 32'(bus.int_req), 32'(m_req));
        if (m_req) chk("model_line", 32'(bus.int_line), 32'(m_line));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        bus.mtc0_we = 0; bus.mtc0_wdata = 32'h0; bus.exc_valid = 0;
        bus.exc_code = 5'd0; bus.exc_bd = 0; bus.exc_ce = 2'd0; bus.int_ack = 0;
    endtask

    typedef struct {
        bit        rd;
        bit        we;
        bit [31:0] wd;
        bit [7:0]  im;
        bit        ie;
        bit        ev;
        bit [4:0]  code;
        bit        bd;
        bit [1:0]  ce;
        bit        ack;
        bit [31:0] e_rd;
        bit        e_req;
        bit [2:0]  e_line;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1, 1, 32'h0080_0200, 8'h02, 1, 0, 5'h00, 0, 2'd0, 0, 32'h0080_0200, 0, 3'd0};
        tbl[1]  = '{1, 0, 32'h0,         8'h02, 1, 0, 5'h00, 0, 2'd0, 0, 32'h0080_0200, 1, 3'd1};
        tbl[2]  = '{1, 0, 32'h0,         8'h02, 1, 0, 5'h00, 1, 2'd0, 1, 32'h8080_0200, 0, 3'd0};
        tbl[3]  = '{1, 0, 32'h0,         8'h02, 1, 0, 5'h00, 0, 2'd0, 0, 32'h8080_0200, 0, 3'd0};
        tbl[4]  = '{1, 0, 32'h0,         8'h02, 0, 0, 5'h00, 0, 2'd0, 0, 32'h8080_0200, 0, 3'd0};
        tbl[5]  = '{1, 0, 32'h0,         8'h02, 1, 0, 5'h00, 0, 2'd0, 0, 32'h8080_0200, 1, 3'd1};
        tbl[6]  = '{1, 0, 32'h0,         8'h02, 1, 1, 5'h0C, 0, 2'd1, 1, 32'h1080_0230, 0, 3'd0};
        tbl[7]  = '{1, 0, 32'h0,         8'h02, 1, 0, 5'h00, 0, 2'd0, 0, 32'h1080_0230, 1, 3'd1};
        tbl[8]  = '{1, 1, 32'h0,         8'h02, 1, 0, 5'h00, 0, 2'd0, 0, 32'h1000_0030, 1, 3'd1};
        tbl[9]  = '{1, 0, 32'h0,         8'h02, 1, 0, 5'h00, 0, 2'd0, 0, 32'h1000_0030, 0, 3'd0};
        tbl[10] = '{1, 1, 32'hFFFF_FFFF, 8'h02, 0, 0, 5'h00, 0, 2'd0, 0, 32'h1080_0330, 0, 3'd0};
        tbl[11] = '{1, 0, 32'h0,         8'h03, 1, 0, 5'h00, 0, 2'd0, 0, 32'h1080_0330, 1, 3'd1};
        tbl[12] = '{1, 0, 32'h0,         8'h01, 1, 0, 5'h00, 0, 2'd0, 0, 32'h1080_0330, 1, 3'd0};
        tbl[13] = '{1, 0, 32'h0,         8'h01, 1, 0, 5'h00, 0, 2'd0, 1, 32'h1080_0300, 0, 3'd0};
        tbl[14] = '{1, 0, 32'h0,         8'h01, 1, 0, 5'h00, 1, 2'd0, 1, 32'h1080_0300, 0, 3'd0};
        tbl[15] = '{0, 0, 32'h0,         8'h01, 0, 0, 5'h00, 0, 2'd0, 0, 32'h0000_0000, 0, 3'd0};
        tbl[16] = '{1, 1, 32'h0,         8'h01, 0, 1, 5'h1F, 1, 2'd3, 0, 32'hB000_007C, 0, 3'd0};

        rst = 1; hw = 6'h3F; timer = 0;
        rst2 = 1; hw2 = 2'b00; timer2 = 0;
        idle_inputs();
        bus.status_im = 8'hFF; bus.int_en = 1; bus.rd_en = 1;
        bus2.mtc0_we = 0; bus2.mtc0_wdata = 32'h0; bus2.exc_valid = 0;
        bus2.exc_code = 5'd0; bus2.exc_bd = 0; bus2.exc_ce = 2'd0; bus2.int_ack = 0;
        bus2.status_im = 8'h00; bus2.int_en = 0; bus2.rd_en = 1;
        model_reset();

        // Reset with all lines high, then release
        repeat (2) begin
            tick();
            chk("rst_rd", bus.read_data, 32'h0);
            chk("rst_req", 32'(bus.int_req), 32'h0);
            chk("rst_line", 32'(bus.int_line), 32'h0);
        end
        rst = 0;
        tick();
        chk("sync_edge1_rd", bus.read_data, 32'h0);
        tick();
        chk("sync_edge2_rd", bus.read_data, 32'h0000_FC00);
        chk("sync_edge2_req", 32'(bus.int_req), 32'h0);
        tick();
        chk("first_req", 32'(bus.int_req), 32'h1);
        chk("first_line", 32'(bus.int_line), 32'h7);

        // Clean reset, then directed table
        rst = 1; hw = 6'h00;
        repeat (2) tick();
        rst = 0;
        foreach (tbl[i]) begin
            bus.rd_en = tbl[i].rd; bus.mtc0_we = tbl[i].we; bus.mtc0_wdata = tbl[i].wd;
            bus.status_im = tbl[i].im; bus.int_en = tbl[i].ie; bus.exc_valid = tbl[i].ev;
            bus.exc_code = tbl[i].code; bus.exc_bd = tbl[i].bd; bus.exc_ce = tbl[i].ce;
            bus.int_ack = tbl[i].ack;
            tick();
            chk($sformatf("tbl%0d_rd", i), bus.read_data, tbl[i].e_rd);
            chk($sformatf("tbl%0d_req", i), 32'(bus.int_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("tbl%0d_line", i), 32'(bus.int_line), 32'(tbl[i].e_line));
        end
        idle_inputs();

        // hw_irq[2] pulse drops before ack
        rst = 1; hw = 6'h00;
        repeat (2) tick();
        rst = 0; bus.status_im = 8'hFF; bus.int_en = 1; bus.rd_en = 1;
        hw = 6'h04;
        repeat (3) tick();
        chk("drop_req_up", 32'(bus.int_req), 32'h1);
        chk("drop_line", 32'(bus.int_line), 32'h4);
        hw = 6'h00;
        tick();
        tick();
        chk("drop_ip_clear", bus.read_data, 32'h0);
        chk("drop_req_hold", 32'(bus.int_req), 32'h1);
        tick();
        chk("drop_req_fall", 32'(bus.int_req), 32'h0);

        // Reset while requesting
        hw = 6'h04;
        begin
            int n;
            n = 0;
            while (!bus.int_req && n < 10) begin tick(); n++; end
            chk("rereq_timeout", 32'(bus.int_req), 32'h1);
        end
        rst = 1;
        tick();
        chk("midreq_rst_rd", bus.read_data, 32'h0);
        chk("midreq_rst_req", 32'(bus.int_req), 32'h0);
        chk("midreq_rst_line", 32'(bus.int_line), 32'h0);
        rst = 0; hw = 6'h00;

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) hw = 6'($urandom);
            if ($urandom_range(0, 3) == 0) timer = ~timer;
            bus.mtc0_we = ($urandom_range(0, 7) == 0);
            bus.mtc0_wdata = $urandom;
            if ($urandom_range(0, 15) == 0) bus.status_im = 8'($urandom);
            bus.int_en = ($urandom_range(0, 3) != 0);
            bus.exc_valid = ($urandom_range(0, 9) == 0);
            bus.exc_code = 5'($urandom);
            bus.exc_bd = 1'($urandom);
            bus.exc_ce = 2'($urandom);
            bus.int_ack = ($urandom_range(0, 2) == 0);
            bus.rd_en = ($urandom_range(0, 7) != 0);
            tick();
        end
        rst = 0; idle_inputs();

        // Reduced configuration: two lines, timer on line 1
        rst2 = 0; hw2 = 2'b00; timer2 = 0;
        tick();
        chk("cfg2_idle_rd", bus2.read_data, 32'h0);
        timer2 = 1;
        tick();
        chk("cfg2_timer_rd", bus2.read_data, 32'h4000_0800);
        hw2 = 2'b11;
        repeat (2) tick();
        chk("cfg2_hw_rd", bus2.read_data, 32'h4000_0C00);
        chk("cfg2_req", 32'(bus2.int_req), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_cause_ctrl.md
Name: cp0_cause_ctrl

Overview:
- Parametrised next-generation CP0 Cause register with an integrated interrupt-request controller.
- Holds BD/TI/CE/IV/IP/ExcCode and synchronises external hardware interrupt lines.
- Supports software-interrupt writes via MTC0, masks pending lines with Status.IM/IE, and runs a request/acknowledge handshake with the pipeline control unit.
- Sits in the CP0 block beside the Status and EPC units.

Parameters:
- NUM_HW_IRQ, 6, number of hardware interrupt lines (1..6), mapped to IP[NUM_HW_IRQ+1:2].
- SYNC_STAGES, 2, flop stages on each hw_irq line (2..3).
- TIMER_LINE, 5, hardware line index (0..NUM_HW_IRQ-1) that timer_irq is ORed into.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- hw_irq  in  NUM_HW_IRQ  asynchronous level-sensitive interrupt lines
- timer_irq  in  1  internal timer compare interrupt, synchronous to clk
- mtc0_we  in  1  MTC0 write to Cause
- mtc0_wdata  in  32  MTC0 write data
- exc_valid  in  1  exception commit this cycle
- exc_code  in  5  ExcCode of committing exception
- exc_bd  in  1  faulting/interrupted instruction is in a delay slot
- exc_ce  in  2  coprocessor number, for CpU exceptions
- status_im  in  8  Status.IM
- int_en  in  1  Status.IE & ~Status.EXL & ~Status.ERL
- rd_en  in  1  MFC0 read of Cause
- int_ack  in  1  pipeline takes the requested interrupt this cycle
- int_req  out  1  interrupt request to pipeline
- int_line  out  3  index of the highest-priority pending IP bit, valid with int_req
- read_data  out  32  Cause value when rd_en=1, else 32'h0

Behaviour:
- Reset: all Cause bits 0, FSM IDLE, int_req=0, int_line=0, all sync flops 0. Reset overrides every other input on the same edge, including mid-REQ.
- Layout:
  - bit 31 BD; bit 30 TI; bits 29:28 CE; bit 23 IV
  - bits 15:8 IP; bits 6:2 ExcCode
  - all other bits read 0 and ignore writes.
- IP[7:2]:
  - Each hw_irq line passes through SYNC_STAGES flops; the last stage is the IP bit itself.
  - A stable input is visible in read_data SYNC_STAGES edges after it changes.
  - IP bits above NUM_HW_IRQ+1 are constant 0.
  - IP[TIMER_LINE+2] = sync(hw_irq[TIMER_LINE]) | registered timer_irq.
- TI: registered copy of timer_irq, 1-cycle latency. IP[7:2] and TI are read-only to MTC0.
- MTC0 write (mtc0_we=1): IP[1:0] <= wdata[9:8]; IV <= wdata[23]. No other field changes.
- Exception commit (exc_valid=1): BD <= exc_bd, CE <= exc_ce, ExcCode <= exc_code.
- Interrupt acknowledge (int_ack in REQ): BD <= exc_bd, ExcCode <= 0, CE unchanged.
- exc_valid and int_ack in the same cycle: exc_valid wins and the interrupt is not taken.
- exc_valid and mtc0_we in the same cycle: both apply; their fields are disjoint.
- pending = IP & status_im.
- FSM states: IDLE, REQ, BLOCK.
  - IDLE -> REQ when int_en & |pending.
    - int_req=1 from the next cycle.
    - int_line is registered on this transition as the highest set pending index (7 highest priority).
  - REQ, int_ack=1 & exc_valid=0 -> BLOCK; Cause updated at the same edge.
  - REQ, exc_valid=1 -> IDLE.
  - REQ, (pending==0 | int_en==0) without ack -> IDLE; int_req drops the next cycle.
  - REQ, otherwise: stay. int_line is re-evaluated each cycle.
  - BLOCK -> IDLE when int_en==0, i.e. once the handler has set EXL. int_req=0 in BLOCK.
  - int_ack outside REQ is ignored.
- int_req and int_line are registered FSM outputs. int_req=1 only in REQ.
- read_data = rd_en ? Cause : 32'h0, combinational from the current registered value. A same-cycle write is not visible until the next cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with hw_irq=6'h3F → read_data=0, int_req=0. After release with IM=8'hFF, int_en=1 → IP=8'hFC visible at edge SYNC_STAGES, int_req=1 one cycle later, int_line=7.
- Software interrupt: mtc0_we, wdata=32'h0080_0200, status_im=8'h02, int_en=1 → IV=1, IP[1]=1, read_data=32'h0080_0200. int_req=1 two cycles after the write; int_line=1.
- Handshake: pending IP[4], int_ack=1 with exc_bd=1 → next cycle BD=1, ExcCode=0, int_req=0, FSM BLOCK. Stays BLOCK until int_en=0, then IDLE.
- Collision: in REQ, exc_valid=1 with exc_code=5'h0C, exc_ce=2'b01, exc_bd=0, plus int_ack=1 → ExcCode=0x0C, CE=1, FSM IDLE. If still pending and int_en=1, re-request follows.
- Drop and reset: hw_irq[2] pulses 3 cycles then clears before ack → int_req falls one cycle after IP[4] clears. A second request with rst asserted while int_req=1 → all zero next edge.
- Configuration NUM_HW_IRQ=2, TIMER_LINE=1: drive timer_irq=1 → TI=1, IP[3]=1, IP[7:4] stay 0 even with hw inputs tied high.
